// File: rtl/vx_dp_ram_arb_if.sv
// Requester-side bus of vx_dp_ram_arb.
//   wr_valid/wr_addr/wr_data -> per-lane write requests, wr_ready <- one-hot write grant
//   rd_valid/rd_addr         -> per-lane read requests,  rd_ready <- one-hot read grant
//   rsp_valid/rsp_data       <- one-hot read response strobe and shared response data
// Lane i occupies [i*ADDRW +: ADDRW] of the address buses and [i*DATAW +: DATAW] of wr_data.
interface vx_dp_ram_arb_if #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned ADDRW    = 8
);
    logic [NUM_REQS-1:0]       wr_valid;
    logic [NUM_REQS*ADDRW-1:0] wr_addr;
    logic [NUM_REQS*DATAW-1:0] wr_data;
    logic [NUM_REQS-1:0]       wr_ready;
    logic [NUM_REQS-1:0]       rd_valid;
    logic [NUM_REQS*ADDRW-1:0] rd_addr;
    logic [NUM_REQS-1:0]       rd_ready;
    logic [NUM_REQS-1:0]       rsp_valid;
    logic [DATAW-1:0]          rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/vx_dp_ram_arb.sv
// Shares one simple dual-port RAM (1 write, 1 read port) between NUM_REQS requesters.
// After reset the RAM is cleared to INIT_VALUE (SIZE cycles), then independent round-robin
// arbiters serve writes and reads. Read responses return RAM_LAT+1 cycles after the grant.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   init_done          high once the clear pass has finished
//   bus                requester interface (vx_dp_ram_arb_if.slave)
//   ram_wren/waddr/wdata  RAM write port
//   ram_raddr/ram_rdata   RAM read port (rdata valid RAM_LAT cycles after raddr)
// Optional feature macro: VX_DP_RAM_ARB_FWD_EN -- a read granted in the same cycle as a write
// to the same address returns the new write data instead of the old RAM word.
module vx_dp_ram_arb #(
    parameter int unsigned      NUM_REQS   = 4,
    parameter int unsigned      DATAW      = 32,
    parameter int unsigned      SIZE       = 256,
    parameter int unsigned      ADDRW      = $clog2(SIZE),
    parameter int unsigned      RAM_LAT    = 1,
    parameter logic [DATAW-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               init_done,
    vx_dp_ram_arb_if.slave     bus,
    output logic               ram_wren,
    output logic [ADDRW-1:0]   ram_waddr,
    output logic [DATAW-1:0]   ram_wdata,
    output logic [ADDRW-1:0]   ram_raddr,
    input  logic [DATAW-1:0]   ram_rdata
);
    localparam int unsigned PTRW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
`ifdef VX_DP_RAM_ARB_FWD_EN
    // Pipeline payload: {lane one-hot, forward hit, forwarded data}
    localparam int unsigned PW = NUM_REQS + 1 + DATAW;
`else
    localparam int unsigned PW = NUM_REQS;
`endif

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDRW-1:0]    cnt_q, cnt_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_REQS-1:0] wr_gnt, rd_gnt;
    logic [PTRW-1:0]     wr_idx, rd_idx;
    logic                wr_any, rd_any;
    logic [PW-1:0]       head, tail;
    logic [NUM_REQS-1:0] rsp_valid_q;
    logic [DATAW-1:0]    rsp_data_q, rsp_data_d;

    // Lane visited at step k of a cyclic scan starting at ptr.
    function automatic logic [PTRW-1:0] rr_lane(input logic [PTRW-1:0] ptr, input int unsigned k);
        return PTRW'((32'(ptr) + k) % NUM_REQS);
    endfunction

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] idx);
        return (32'(idx) == NUM_REQS - 1) ? PTRW'(0) : idx + PTRW'(1);
    endfunction

    always_comb begin
        wr_any = 1'b0;
        wr_idx = '0;
        wr_gnt = '0;
        rd_any = 1'b0;
        rd_idx = '0;
        rd_gnt = '0;
        if (state_q == StRun) begin
            for (int unsigned k = 0; k < NUM_REQS; k++) begin
                if (!wr_any && bus.wr_valid[rr_lane(wr_ptr_q, k)]) begin
                    wr_any = 1'b1;
                    wr_idx = rr_lane(wr_ptr_q, k);
                end
                if (!rd_any && bus.rd_valid[rr_lane(rd_ptr_q, k)]) begin
                    rd_any = 1'b1;
                    rd_idx = rr_lane(rd_ptr_q, k);
                end
            end
            if (wr_any) wr_gnt[wr_idx] = 1'b1;
            if (rd_any) rd_gnt[rd_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_wren  = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        case (state_q)
            StClear: begin
                ram_wren  = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = INIT_VALUE;
                cnt_d     = cnt_q + ADDRW'(1);
                if (cnt_q == ADDRW'(SIZE - 1)) state_d = StRun;
            end
            StRun: begin
                if (wr_any) begin
                    ram_wren  = 1'b1;
                    ram_waddr = bus.wr_addr[wr_idx*ADDRW +: ADDRW];
                    ram_wdata = bus.wr_data[wr_idx*DATAW +: DATAW];
                    wr_ptr_d  = ptr_next(wr_idx);
                end
                if (rd_any) begin
                    ram_raddr = bus.rd_addr[rd_idx*ADDRW +: ADDRW];
                    rd_ptr_d  = ptr_next(rd_idx);
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef VX_DP_RAM_ARB_FWD_EN
    logic fwd_hit;
    assign fwd_hit = wr_any && rd_any && (ram_waddr == ram_raddr);
    assign head    = {rd_gnt, fwd_hit, ram_wdata};
    assign rsp_data_d = tail[DATAW] ? tail[DATAW-1:0] : ram_rdata;
`else
    assign head       = rd_gnt;
    assign rsp_data_d = ram_rdata;
`endif

    // Delay the grant (and forward payload) by RAM_LAT so it lines up with ram_rdata;
    // the response register below adds the final cycle.
    if (RAM_LAT == 0) begin : g_lat0
        assign tail = head;
    end else begin : g_lat
        logic [PW-1:0] pipe_q [RAM_LAT];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= head;
                for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign tail = pipe_q[RAM_LAT-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tail[PW-1 -: NUM_REQS];
            if (|tail[PW-1 -: NUM_REQS]) rsp_data_q <= rsp_data_d;
        end
    end

    assign init_done     = (state_q == StRun);
    assign bus.wr_ready  = wr_gnt;
    assign bus.rd_ready  = rd_gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
